// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   Registered RV32 decode stage between fetch and issue. Every raw
//   instruction is split into its fields, a sign-extended immediate, an
//   instruction type and its PC. Illegal encodings are flagged, depending on
//   the enabled extensions. Results are held in a 2-entry skid buffer
//   (SKID=1) or in a single register (SKID=0). Both sides use valid/ready
//   handshakes.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   flush_i        synchronous flush; empties the buffer, drops same-cycle input
//   in_valid_i     raw instruction valid
//   in_ready_o     stage can accept an instruction this cycle
//   raw_instr_i    raw 32-bit instruction
//   pc_i           PC of raw_instr_i
//   out_valid_o    decoded entry valid
//   out_ready_i    consumer accepts the decoded entry
//   instr_o        {funct7, rs2, rs1, funct3, rd, opcode[6:0]}; unused fields 0
//   imm_o          sign-extended immediate
//   type_o         0=R 1=I 2=S 3=SB 4=U 5=UJ
//   pc_o           PC of the decoded entry
//   illegal_o      entry is an illegal encoding
//   illegal_cnt_o  saturating count of accepted illegal instructions
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN     = 32,
    parameter int EN_M     = 1,
    parameter int EN_ZICSR = 1,
    parameter int SKID     = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      raw_instr_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      instr_o,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       type_o,
    output logic [XLEN-1:0]  pc_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    localparam logic [2:0] TYPE_R  = 3'd0;
    localparam logic [2:0] TYPE_I  = 3'd1;
    localparam logic [2:0] TYPE_S  = 3'd2;
    localparam logic [2:0] TYPE_SB = 3'd3;
    localparam logic [2:0] TYPE_U  = 3'd4;
    localparam logic [2:0] TYPE_UJ = 3'd5;

    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_FULL = 2'd2} state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic [XLEN-1:0] pc;
        logic            ill;
    } entry_t;

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    // ---------------- combinational decode of the incoming instruction ----
    logic [4:0]  w_op;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3_o;
    logic [6:0]  w_f7_o;
    logic [31:0] w_imm32;
    logic [2:0]  w_type;
    logic        w_bad;
    entry_t      w_dec;

    assign w_op    = raw_instr_i[6:2];
    assign w_f3    = raw_instr_i[14:12];
    assign w_f7    = raw_instr_i[31:25];
    assign w_imm_i = {{20{raw_instr_i[31]}}, raw_instr_i[31:20]};
    assign w_imm_s = {{20{raw_instr_i[31]}}, raw_instr_i[31:25], raw_instr_i[11:7]};
    assign w_imm_b = {{19{raw_instr_i[31]}}, raw_instr_i[31], raw_instr_i[7],
                      raw_instr_i[30:25], raw_instr_i[11:8], 1'b0};
    assign w_imm_u = {raw_instr_i[31:12], 12'b0};
    assign w_imm_j = {{11{raw_instr_i[31]}}, raw_instr_i[31], raw_instr_i[19:12],
                      raw_instr_i[20], raw_instr_i[30:21], 1'b0};

    always_comb begin
        w_type  = TYPE_R;
        w_imm32 = '0;
        w_rd    = '0;
        w_rs1   = '0;
        w_rs2   = '0;
        w_f3_o  = '0;
        w_f7_o  = '0;
        w_bad   = 1'b0;
        case (w_op)
            5'b00000, 5'b00011, 5'b00100, 5'b11001, 5'b11100: begin
                w_type  = TYPE_I;
                w_imm32 = w_imm_i;
                w_rd    = raw_instr_i[11:7];
                w_rs1   = raw_instr_i[19:15];
                w_f3_o  = w_f3;
                case (w_op)
                    5'b00000: w_bad = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
                    // shift-immediates carry funct7 in imm[11:5]
                    5'b00100: w_bad = ((w_f3 == 3'b001) && (w_f7 != 7'b0000000)) ||
                                      ((w_f3 == 3'b101) && (w_f7 != 7'b0000000) &&
                                       (w_f7 != 7'b0100000));
                    5'b11001: w_bad = (w_f3 != 3'b000);
                    5'b11100: w_bad = (w_f3 != 3'b000) && (EN_ZICSR == 0);
                    default:  w_bad = 1'b0;
                endcase
            end
            5'b00101, 5'b01101: begin
                w_type  = TYPE_U;
                w_imm32 = w_imm_u;
                w_rd    = raw_instr_i[11:7];
            end
            5'b01000: begin
                w_type  = TYPE_S;
                w_imm32 = w_imm_s;
                w_rs1   = raw_instr_i[19:15];
                w_rs2   = raw_instr_i[24:20];
                w_f3_o  = w_f3;
                w_bad   = (w_f3 >= 3'b011);
            end
            5'b01100: begin
                w_type  = TYPE_R;
                w_rd    = raw_instr_i[11:7];
                w_rs1   = raw_instr_i[19:15];
                w_rs2   = raw_instr_i[24:20];
                w_f3_o  = w_f3;
                w_f7_o  = w_f7;
                w_bad   = !((w_f7 == 7'b0000000) ||
                            ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))) ||
                            ((w_f7 == 7'b0000001) && (EN_M != 0)));
            end
            5'b11000: begin
                w_type  = TYPE_SB;
                w_imm32 = w_imm_b;
                w_rs1   = raw_instr_i[19:15];
                w_rs2   = raw_instr_i[24:20];
                w_f3_o  = w_f3;
                w_bad   = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            5'b11011: begin
                w_type  = TYPE_UJ;
                w_imm32 = w_imm_j;
                w_rd    = raw_instr_i[11:7];
            end
            default: w_bad = 1'b1;
        endcase
        if (raw_instr_i[1:0] != 2'b11) w_bad = 1'b1;
        // illegal entries keep only opcode and PC, reported as R-type
        if (w_bad) begin
            w_type  = TYPE_R;
            w_imm32 = '0;
            w_rd    = '0;
            w_rs1   = '0;
            w_rs2   = '0;
            w_f3_o  = '0;
            w_f7_o  = '0;
        end
    end

    assign w_dec.instr = {w_f7_o, w_rs2, w_rs1, w_f3_o, w_rd, raw_instr_i[6:0]};
    assign w_dec.imm   = sext32(w_imm32);
    assign w_dec.typ   = w_type;
    assign w_dec.pc    = pc_i;
    assign w_dec.ill   = w_bad;

    // ---------------- buffer control FSM -----------------------------------
    state_t          r_state, w_state_nxt;
    logic            r_out_valid, r_in_ready;
    logic [CNT_W-1:0] r_cnt;
    entry_t          r_out, r_skid;
    logic            w_accept, w_drain;
    logic            w_load_out, w_load_skid, w_out_from_skid;
    logic            w_cnt_inc;

    // SKID=0 falls back to a single register with a combinational ready
    assign in_ready_o = (SKID != 0) ? r_in_ready : (!r_out_valid || out_ready_i);
    assign w_accept   = in_valid_i && in_ready_o;
    assign w_drain    = r_out_valid && out_ready_i;
    assign w_cnt_inc  = w_accept && !flush_i && w_bad && (r_cnt != '1);

    always_comb begin
        w_state_nxt     = r_state;
        w_load_out      = 1'b0;
        w_load_skid     = 1'b0;
        w_out_from_skid = 1'b0;
        if (flush_i) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) begin
                    w_state_nxt = S_ONE;
                    w_load_out  = 1'b1;
                end
                S_ONE: begin
                    if (w_accept && w_drain) begin
                        w_load_out = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = S_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_drain) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: if (w_drain) begin
                    w_state_nxt     = S_ONE;
                    w_out_from_skid = 1'b1;
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != S_EMPTY);
            r_in_ready  <= (w_state_nxt != S_FULL);
            if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
        end
    end

    // ---------------- entry registers (head drives the outputs) ------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_out)           r_out <= w_dec;
            else if (w_out_from_skid) r_out <= r_skid;
            if (w_load_skid)          r_skid <= w_dec;
        end
    end

    assign out_valid_o   = r_out_valid;
    assign instr_o       = r_out.instr;
    assign imm_o         = r_out.imm;
    assign type_o        = r_out.typ;
    assign pc_o          = r_out.pc;
    assign illegal_o     = r_out.ill;
    assign illegal_cnt_o = r_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//   Bench for decode_stage. Four instances share one stimulus stream:
//   a (defaults), b (EN_M=0, EN_ZICSR=0), c (CNT_W=2), d (SKID=0).
//   A queue-based model predicts handshake, ordering, decoded fields
//   and illegal counts; directed sequences pin literal values.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_SB = 3'd3,
                           T_U = 3'd4, T_UJ = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] raw, pc;

    always #5 clk = ~clk;

    logic        rdy_a, val_a, ill_a, rdy_b, val_b, ill_b;
    logic        rdy_c, val_c, ill_c, rdy_d, val_d, ill_d;
    logic [31:0] instr_a, imm_a, pc_a, instr_b, imm_b, pc_b;
    logic [31:0] instr_c, imm_c, pc_c, instr_d, imm_d, pc_d;
    logic [2:0]  type_a, type_b, type_c, type_d;
    logic [15:0] cnt_a, cnt_b, cnt_d;
    logic [1:0]  cnt_c;

    decode_stage dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(rdy_a), .raw_instr_i(raw), .pc_i(pc), .out_valid_o(val_a),
        .out_ready_i(out_ready), .instr_o(instr_a), .imm_o(imm_a), .type_o(type_a),
        .pc_o(pc_a), .illegal_o(ill_a), .illegal_cnt_o(cnt_a));

    decode_stage #(.EN_M(0), .EN_ZICSR(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(rdy_b), .raw_instr_i(raw), .pc_i(pc), .out_valid_o(val_b),
        .out_ready_i(out_ready), .instr_o(instr_b), .imm_o(imm_b), .type_o(type_b),
        .pc_o(pc_b), .illegal_o(ill_b), .illegal_cnt_o(cnt_b));

    decode_stage #(.CNT_W(2)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(rdy_c), .raw_instr_i(raw), .pc_i(pc), .out_valid_o(val_c),
        .out_ready_i(out_ready), .instr_o(instr_c), .imm_o(imm_c), .type_o(type_c),
        .pc_o(pc_c), .illegal_o(ill_c), .illegal_cnt_o(cnt_c));

    decode_stage #(.SKID(0)) dut_d (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(rdy_d), .raw_instr_i(raw), .pc_i(pc), .out_valid_o(val_d),
        .out_ready_i(out_ready), .instr_o(instr_d), .imm_o(imm_d), .type_o(type_d),
        .pc_o(pc_d), .illegal_o(ill_d), .illegal_cnt_o(cnt_d));

    int total = 0;
    int bad   = 0;

    task automatic ch(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] raw;
        logic [31:0] pc;
    } item_t;

    // Expected decode, written from the encoding rules
    function automatic exp_t model_dec(input logic [31:0] r, input bit en_m, input bit en_z);
        exp_t e;
        logic signed [31:0] sr;
        logic [4:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit u_rd, u_rs1, u_rs2, u_f3, u_f7;
        sr = r; op = r[6:2]; f3 = r[14:12]; f7 = r[31:25];
        e.ill = 1'b0; e.typ = T_R; e.imm = '0;
        u_rd = 0; u_rs1 = 0; u_rs2 = 0; u_f3 = 0; u_f7 = 0;
        if (op inside {5'd0, 5'd3, 5'd4, 5'd25, 5'd28}) begin
            e.typ = T_I; e.imm = 32'(sr >>> 20); u_rd = 1; u_rs1 = 1; u_f3 = 1;
        end else if (op inside {5'd5, 5'd13}) begin
            e.typ = T_U; e.imm = r & 32'hFFFFF000; u_rd = 1;
        end else if (op == 5'd8) begin
            e.typ = T_S; e.imm = 32'((sr >>> 25) << 5) | 32'(r[11:7]);
            u_rs1 = 1; u_rs2 = 1; u_f3 = 1;
        end else if (op == 5'd12) begin
            e.typ = T_R; u_rd = 1; u_rs1 = 1; u_rs2 = 1; u_f3 = 1; u_f7 = 1;
        end else if (op == 5'd24) begin
            e.typ = T_SB;
            e.imm = 32'((sr >>> 31) << 12) | (32'(r[7]) << 11) | (32'(r[30:25]) << 5) |
                    (32'(r[11:8]) << 1);
            u_rs1 = 1; u_rs2 = 1; u_f3 = 1;
        end else if (op == 5'd27) begin
            e.typ = T_UJ;
            e.imm = 32'((sr >>> 31) << 20) | (32'(r[19:12]) << 12) | (32'(r[20]) << 11) |
                    (32'(r[30:21]) << 1);
            u_rd = 1;
        end else e.ill = 1'b1;
        if (r[1:0] != 2'b11) e.ill = 1'b1;
        if (op == 5'd12 && !(f7 == 7'h00 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}) ||
                             (f7 == 7'h01 && en_m))) e.ill = 1'b1;
        if (op == 5'd4 && f3 == 3'd1 && f7 != 7'h00) e.ill = 1'b1;
        if (op == 5'd4 && f3 == 3'd5 && !(f7 inside {7'h00, 7'h20})) e.ill = 1'b1;
        if (op == 5'd0 && f3 inside {3'd3, 3'd6, 3'd7}) e.ill = 1'b1;
        if (op == 5'd8 && f3 >= 3'd3) e.ill = 1'b1;
        if (op == 5'd24 && f3 inside {3'd2, 3'd3}) e.ill = 1'b1;
        if (op == 5'd25 && f3 != 3'd0) e.ill = 1'b1;
        if (op == 5'd28 && f3 != 3'd0 && !en_z) e.ill = 1'b1;
        e.instr = {(u_f7 ? f7 : 7'd0), (u_rs2 ? r[24:20] : 5'd0), (u_rs1 ? r[19:15] : 5'd0),
                   (u_f3 ? f3 : 3'd0), (u_rd ? r[11:7] : 5'd0), r[6:0]};
        if (e.ill) begin
            e.instr = {25'd0, r[6:0]}; e.imm = '0; e.typ = T_R;
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 15))
            0:  r[6:2] = 5'b00000;
            1:  r[6:2] = 5'b00011;
            2:  r[6:2] = 5'b00100;
            3:  r[6:2] = 5'b11001;
            4:  r[6:2] = 5'b11100;
            5:  r[6:2] = 5'b00101;
            6:  r[6:2] = 5'b01101;
            7:  r[6:2] = 5'b01000;
            8:  r[6:2] = 5'b01100;
            9:  r[6:2] = 5'b11000;
            10: r[6:2] = 5'b11011;
            11: r[6:2] = 5'b10001;
            12: r[6:2] = 5'b01100;
            default: ;
        endcase
        if ($urandom_range(0, 15) != 0) r[1:0] = 2'b11;
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        return r;
    endfunction

    // Reference state: FIFO of depth 2 (skid) and depth 1 (SKID=0)
    item_t qs[$];
    item_t q0[$];
    int unsigned mc_a, mc_b, mc_c, mc_d;

    initial begin
        bit acc1, drn1, acc0, drn0;
        item_t it;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                qs.delete(); q0.delete();
                mc_a = 0; mc_b = 0; mc_c = 0; mc_d = 0;
            end else begin
                acc1 = in_valid && (qs.size() < 2);
                drn1 = (qs.size() > 0) && out_ready;
                acc0 = in_valid && ((q0.size() == 0) || out_ready);
                drn0 = (q0.size() > 0) && out_ready;
                it.raw = raw; it.pc = pc;
                if (flush) begin
                    qs.delete(); q0.delete();
                end else begin
                    if (drn1) void'(qs.pop_front());
                    if (acc1) begin
                        qs.push_back(it);
                        if (model_dec(raw, 1, 1).ill && mc_a < 65535) mc_a++;
                        if (model_dec(raw, 0, 0).ill && mc_b < 65535) mc_b++;
                        if (model_dec(raw, 1, 1).ill && mc_c < 3) mc_c++;
                    end
                    if (drn0) void'(q0.pop_front());
                    if (acc0) begin
                        q0.push_back(it);
                        if (model_dec(raw, 1, 1).ill && mc_d < 65535) mc_d++;
                    end
                end
            end
        end
    end

    // Compare every cycle while out of reset
    initial begin
        exp_t ea, eb, ed;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                ch("ready_a", 64'(rdy_a), 64'(qs.size() < 2));
                ch("ready_b", 64'(rdy_b), 64'(qs.size() < 2));
                ch("valid_a", 64'(val_a), 64'(qs.size() != 0));
                ch("valid_c", 64'(val_c), 64'(qs.size() != 0));
                if (qs.size() != 0) begin
                    ea = model_dec(qs[0].raw, 1, 1);
                    eb = model_dec(qs[0].raw, 0, 0);
                    ch("instr_a", 64'(instr_a), 64'(ea.instr));
                    ch("imm_a",   64'(imm_a),   64'(ea.imm));
                    ch("type_a",  64'(type_a),  64'(ea.typ));
                    ch("ill_a",   64'(ill_a),   64'(ea.ill));
                    ch("pc_a",    64'(pc_a),    64'(qs[0].pc));
                    ch("instr_b", 64'(instr_b), 64'(eb.instr));
                    ch("imm_b",   64'(imm_b),   64'(eb.imm));
                    ch("type_b",  64'(type_b),  64'(eb.typ));
                    ch("ill_b",   64'(ill_b),   64'(eb.ill));
                end
                ch("cnt_a", 64'(cnt_a), 64'(mc_a));
                ch("cnt_b", 64'(cnt_b), 64'(mc_b));
                ch("cnt_c", 64'(cnt_c), 64'(mc_c));
                ch("ready_d", 64'(rdy_d), 64'((q0.size() == 0) || out_ready));
                ch("valid_d", 64'(val_d), 64'(q0.size() != 0));
                if (q0.size() != 0) begin
                    ed = model_dec(q0[0].raw, 1, 1);
                    ch("instr_d", 64'(instr_d), 64'(ed.instr));
                    ch("imm_d",   64'(imm_d),   64'(ed.imm));
                    ch("ill_d",   64'(ill_d),   64'(ed.ill));
                    ch("pc_d",    64'(pc_d),    64'(q0[0].pc));
                end
                ch("cnt_d", 64'(cnt_d), 64'(mc_d));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] r, input logic [31:0] p);
        in_valid = 1'b1; raw = r; pc = p;
        step();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        raw = '0; pc = '0;
        repeat (2) @(posedge clk);
        #1;
        ch("rst_valid", 64'(val_a), 64'(0));
        ch("rst_ready", 64'(rdy_a), 64'(1));
        ch("rst_instr", 64'(instr_a), 64'(0));
        ch("rst_imm",   64'(imm_a), 64'(0));
        ch("rst_type",  64'(type_a), 64'(0));
        ch("rst_pc",    64'(pc_a), 64'(0));
        ch("rst_ill",   64'(ill_a), 64'(0));
        ch("rst_cnt",   64'(cnt_a), 64'(0));
        rst_n = 1'b1;
        step();

        // addi x1, x0, -1
        out_ready = 1'b1;
        push(32'hFFF00093, 32'h100);
        in_valid = 1'b0;
        ch("addi_valid", 64'(val_a), 64'(1));
        ch("addi_instr", 64'(instr_a), 64'h93);
        ch("addi_imm",   64'(imm_a), 64'hFFFFFFFF);
        ch("addi_type",  64'(type_a), 64'(T_I));
        ch("addi_pc",    64'(pc_a), 64'h100);
        ch("addi_ill",   64'(ill_a), 64'(0));
        step();

        // branch then jal, back to back
        push(32'hFE000EE3, 32'h200);
        ch("sb_imm",   64'(imm_a), 64'hFFFFFFFC);
        ch("sb_type",  64'(type_a), 64'(T_SB));
        ch("sb_instr", 64'(instr_a), 64'h63);
        push(32'h001000EF, 32'h204);
        in_valid = 1'b0;
        ch("uj_imm",   64'(imm_a), 64'h800);
        ch("uj_type",  64'(type_a), 64'(T_UJ));
        ch("uj_instr", 64'(instr_a), 64'hEF);
        step();

        // fill the skid buffer while stalled, then release
        out_ready = 1'b0;
        push(32'h00100093, 32'h300);
        ch("skid_rdy1", 64'(rdy_a), 64'(1));
        push(32'h00200093, 32'h304);
        ch("skid_rdy2", 64'(rdy_a), 64'(0));
        push(32'h00300093, 32'h308);
        ch("skid_hold", 64'(pc_a), 64'h300);
        out_ready = 1'b1;
        step();
        ch("skid_2nd", 64'(pc_a), 64'h304);
        step();
        in_valid = 1'b0;
        ch("skid_3rd", 64'(pc_a), 64'h308);
        step();

        // mul x3, x1, x2 : legal with M, illegal without
        push(32'h022081B3, 32'h380);
        in_valid = 1'b0;
        ch("mul_a_instr", 64'(instr_a), 64'h022081B3);
        ch("mul_a_ill",   64'(ill_a), 64'(0));
        ch("mul_b_ill",   64'(ill_b), 64'(1));
        ch("mul_b_instr", 64'(instr_b), 64'h33);
        ch("mul_b_imm",   64'(imm_b), 64'(0));
        ch("mul_b_type",  64'(type_b), 64'(T_R));
        ch("mul_b_cnt",   64'(cnt_b), 64'(1));
        step();

        // flush while full, and flush of an acceptable illegal input
        out_ready = 1'b0;
        push(32'h00100093, 32'h400);
        push(32'h00100093, 32'h404);
        ch("fl_full", 64'(rdy_a), 64'(0));
        flush = 1'b1;
        push(32'h00000000, 32'h500);
        flush = 1'b0; in_valid = 1'b0;
        ch("fl_valid", 64'(val_a), 64'(0));
        ch("fl_ready", 64'(rdy_a), 64'(1));
        push(32'h00100093, 32'h600);
        flush = 1'b1;
        push(32'h00000000, 32'h604);
        flush = 1'b0; in_valid = 1'b0;
        ch("fl2_valid", 64'(val_a), 64'(0));
        ch("fl2_cnt_a", 64'(cnt_a), 64'(0));
        ch("fl2_cnt_b", 64'(cnt_b), 64'(1));
        out_ready = 1'b1;
        step();
        ch("fl_gone", 64'(val_a), 64'(0));

        // asynchronous reset with two entries buffered
        out_ready = 1'b0;
        push(32'h00100093, 32'h700);
        push(32'h00000000, 32'h704);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        ch("ar_valid", 64'(val_a), 64'(0));
        ch("ar_ready", 64'(rdy_a), 64'(1));
        ch("ar_instr", 64'(instr_a), 64'(0));
        ch("ar_pc",    64'(pc_a), 64'(0));
        ch("ar_cnt_b", 64'(cnt_b), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        push(32'hFFF00093, 32'h800);
        in_valid = 1'b0;
        ch("post_instr", 64'(instr_a), 64'h93);
        ch("post_imm",   64'(imm_a), 64'hFFFFFFFF);
        ch("post_pc",    64'(pc_a), 64'h800);
        step();

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            raw       = rnd_instr();
            pc        = $urandom & 32'hFFFFFFFC;
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised RV32 decode stage between fetch and issue. Replaces the purely combinational decoder.
- Splits each raw instruction into a Common::decoded_instr_t plus a sign-extended immediate, instruction type and PC.
- Flags illegal encodings per enabled extension, buffers results in a 2-entry skid buffer with valid/ready handshakes on both sides, and supports pipeline flush and a saturating illegal-instruction counter.

Parameters:
- XLEN, 32, width of PC and immediate (immediates sign-extended to XLEN).
- EN_M, 1, accept RV32M (opcode 01100, funct7 0000001); when 0 these are illegal.
- EN_ZICSR, 1, accept SYSTEM with funct3 != 000; when 0 these are illegal.
- SKID, 1, 1 = 2-entry skid buffer (in_ready_o registered); 0 = single register, in_ready_o = !valid | out_ready_i.
- CNT_W, 16, width of illegal counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous pipeline flush.
- in_valid_i  in  1  raw instruction valid.
- in_ready_o  out  1  stage can accept.
- raw_instr_i  in  32  Common::raw_instr_t.
- pc_i  in  XLEN  PC of raw_instr_i.
- out_valid_o  out  1  decoded entry valid.
- out_ready_i  in  1  consumer accepts.
- instr_o  out  decoded_instr_t  opcode/rd/rs1/rs2/funct3/funct7.
- imm_o  out  XLEN  sign-extended immediate.
- type_o  out  instr_type_t  I/U/R/S/SB/UJ.
- pc_o  out  XLEN  PC of decoded entry.
- illegal_o  out  1  entry is an illegal encoding.
- illegal_cnt_o  out  CNT_W  saturating count of illegal entries accepted.

Behaviour:
- Reset (async, rst_ni=0): buffer empty; out_valid_o=0, in_ready_o=1, instr_o/imm_o/pc_o/type_o/illegal_o=0, illegal_cnt_o=0. Reset mid-transfer discards all entries.
- Transfers: input on in_valid_i & in_ready_o; output on out_valid_o & out_ready_i. Latency 1 cycle: an instruction accepted in cycle N is visible on outputs at N+1.
- Outputs are driven only from registers. Outputs hold stable while out_valid_o=1 & !out_ready_i.
- Skid (SKID=1): states EMPTY, ONE, FULL.
  - EMPTY -> ONE on accept.
  - ONE -> FULL on accept without drain; ONE -> EMPTY on drain without accept; ONE stays ONE on simultaneous accept+drain.
  - FULL -> ONE on drain. No accept in FULL (in_ready_o=0).
  - in_ready_o = (state != FULL), registered.
  - Order is strictly FIFO.
- Decode fields, type and immediate:
  - Types: 00000/00011/00100/11001/11100 = I; 00101/01101 = U; 01000 = S; 01100 = R; 11000 = SB; 11011 = UJ.
  - Immediates: I = sext(raw[31:20]); S = sext({raw[31:25],raw[11:7]}); SB = sext({raw[31],raw[7],raw[30:25],raw[11:8],0}); U = {raw[31:12],12'b0}; UJ = sext({raw[31],raw[19:12],raw[20],raw[30:21],0}).
  - Unused fields are 0.
- Illegal (illegal_o=1) when any of:
  - raw[1:0] != 11.
  - Unlisted opcode (including 10001).
  - R-type with funct7 not 0000000, not 0100000 (funct3 000/101 only), and not 0000001 (only if EN_M).
  - OP-IMM with funct3 001 & funct7 != 0, or funct3 101 & funct7 not 0000000/0100000.
  - Load with funct3 011/110/111.
  - Store with funct3 >= 011.
  - Branch with funct3 010/011.
  - JALR with funct3 != 000.
  - SYSTEM with funct3 != 000 & !EN_ZICSR.
- Illegal entry handling: fields and imm_o are 0, type_o = R, pc_o and opcode preserved. The entry still flows through the handshake.
- illegal_cnt_o: increments on accept of an illegal instruction; saturates at all-ones; not cleared by flush.
- flush_i: clears the buffer to EMPTY at the clock edge. An input accepted in the same cycle is discarded and not counted. Flush has priority over accept and drain. in_ready_o=1 the following cycle.

Test Plan:
- Reset, then push 0xFFF00093 at pc 0x100 with out_ready_i=1 -> next cycle out_valid_o=1, rd=1, rs1=0, funct3=0, type I, imm_o=0xFFFFFFFF, pc_o=0x100, illegal_o=0.
- Push 0xFE000EE3 then 0x001000EF back-to-back -> imm_o 0xFFFFFFFC (SB), then 0x00000800 (UJ, rd=1), in order.
- out_ready_i=0, push 3 instructions -> first two accepted, in_ready_o=0 after the 2nd; raise out_ready_i -> drained in order, third accepted once in_ready_o returns to 1.
- EN_M=0, push 0x022081B3 -> illegal_o=1, fields 0, illegal_cnt_o=1; with EN_M=1 -> legal, rd=3, rs1=1, rs2=2, funct7=0000001.
- Buffer FULL, assert flush_i while in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, flushed input never appears.
- Drop rst_ni mid-stream with 2 entries buffered -> outputs zero immediately (asynchronously), illegal_cnt_o=0; the first post-reset push decodes correctly.
